// File: rtl/cic_dec_ctrl.sv
// -----------------------------------------------------------------------------
// cic_dec_ctrl
//
// Sequencing controller for a CIC decimator. Counts input sample strobes,
// issues the integrator enable for every sample and the comb enable once per
// decimation group, and only switches to a newly written decimation rate on a
// group boundary. Each comb output word is serialized MSB-byte first onto an
// 8-bit valid/ready stream with first/last framing; words that arrive while
// the serializer is still busy are dropped and flagged in a sticky overrun bit.
//
// Ports
//   clk        in   single clock
//   rst        in   synchronous reset, active-high
//   in_valid   in   one-cycle strobe, one input sample present
//   cfg_we     in   decimation-rate write strobe
//   cfg_rate   in   new decimation rate (0 and 1 are clamped to 2)
//   ovr_clr    in   clears the sticky overrun flag
//   integ_en   out  integrator advance, one cycle after each in_valid
//   comb_en    out  comb advance, one cycle after each group-closing in_valid
//   cic_valid  in   comb output word valid, one-cycle pulse
//   cic_data   in   comb output word (8*NBYTES bits)
//   out_byte   out  serialized byte, most-significant first
//   out_valid  out  out_byte is valid
//   out_ready  in   downstream accepts the byte
//   out_first  out  byte is the first of its word
//   out_last   out  byte is the last of its word
//   overrun    out  sticky: a word was dropped
//   rate       out  decimation rate currently in force
// -----------------------------------------------------------------------------
module cic_dec_ctrl #(
    parameter int unsigned RATE_W       = 8,
    parameter int unsigned DEFAULT_RATE = 32,
    parameter int unsigned NBYTES       = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  cfg_we,
    input  logic [RATE_W-1:0]     cfg_rate,
    input  logic                  ovr_clr,
    output logic                  integ_en,
    output logic                  comb_en,
    input  logic                  cic_valid,
    input  logic [8*NBYTES-1:0]   cic_data,
    output logic [7:0]            out_byte,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_first,
    output logic                  out_last,
    output logic                  overrun,
    output logic [RATE_W-1:0]     rate
);

    localparam int unsigned WORD_W = 8 * NBYTES;
    localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [IDX_W-1:0]  IDX_FIRST = IDX_W'(NBYTES - 1);
    localparam logic [RATE_W-1:0] RATE_RST  = RATE_W'(DEFAULT_RATE);
    localparam logic [RATE_W-1:0] RATE_MIN  = RATE_W'(2);

    // -------------------------------------------------------------------------
    // Sample counting and rate control
    // -------------------------------------------------------------------------
    logic [RATE_W-1:0] cnt_q, cnt_d;
    logic [RATE_W-1:0] rate_q, rate_d;
    logic [RATE_W-1:0] pending_q, pending_d;
    logic              integ_en_q;
    logic              comb_en_q;
    logic              boundary;

    always_comb begin
        boundary  = in_valid && (cnt_q == (rate_q - RATE_W'(1)));
        cnt_d     = cnt_q;
        rate_d    = rate_q;
        pending_d = pending_q;

        if (in_valid) begin
            if (boundary) begin
                cnt_d  = '0;
                // Uses pending as it stood before this cycle, so a write that
                // coincides with the boundary waits for the next one.
                rate_d = pending_q;
            end else begin
                cnt_d = cnt_q + RATE_W'(1);
            end
        end

        if (cfg_we) begin
            pending_d = (cfg_rate < RATE_MIN) ? RATE_MIN : cfg_rate;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            rate_q     <= RATE_RST;
            pending_q  <= RATE_RST;
            integ_en_q <= 1'b0;
            comb_en_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            rate_q     <= rate_d;
            pending_q  <= pending_d;
            integ_en_q <= in_valid;
            comb_en_q  <= boundary;
        end
    end

    assign integ_en = integ_en_q;
    assign comb_en  = comb_en_q;
    assign rate     = rate_q;

    // -------------------------------------------------------------------------
    // Output serializer
    // -------------------------------------------------------------------------
    typedef enum logic [0:0] {
        StIdle,
        StSend
    } state_e;

    state_e            state_q, state_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              overrun_q, overrun_d;
    logic              sending;
    logic              hs;
    logic              last_hs;
    logic              load;
    logic              ovr_set;

    // Derived from registered state only, so no path from out_ready to out_valid.
    assign sending = (state_q == StSend);
    assign hs      = sending && out_ready;
    assign last_hs = hs && (idx_q == '0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load    = 1'b0;
        ovr_set = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cic_valid) begin
                    state_d = StSend;
                    load    = 1'b1;
                end
            end
            StSend: begin
                if (hs) begin
                    if (idx_q != '0) begin
                        idx_d = idx_q - IDX_W'(1);
                    end else if (!cic_valid) begin
                        state_d = StIdle;
                    end
                end
                // A word is only accepted when the slot frees up this very cycle.
                if (cic_valid) begin
                    if (last_hs) begin
                        load = 1'b1;
                    end else begin
                        ovr_set = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            idx_d = IDX_FIRST;
        end

        word_d = load ? cic_data : word_q;

        // Set wins over clear.
        if (ovr_set) begin
            overrun_d = 1'b1;
        end else if (ovr_clr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q    <= '0;
            idx_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            word_q    <= word_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
        end
    end

    // Outputs
    always_comb begin
        out_valid = sending;
        out_first = sending && (idx_q == IDX_FIRST);
        out_last  = sending && (idx_q == '0);
        out_byte  = '0;
        if (sending) begin
            out_byte = 8'(word_q >> {idx_q, 3'b000});
        end
    end

    assign overrun = overrun_q;

endmodule

// File: tb/tb_cic_dec_ctrl.sv
module tb_cic_dec_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, cfg_we, ovr_clr, cic_valid, out_ready;
    logic [7:0]  cfg_rate;
    logic [15:0] cic_data;
    logic        integ_en, comb_en, out_valid, out_first, out_last, overrun;
    logic [7:0]  out_byte, rate;

    cic_dec_ctrl #(
        .RATE_W       (8),
        .DEFAULT_RATE (32),
        .NBYTES       (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .cfg_we    (cfg_we),
        .cfg_rate  (cfg_rate),
        .ovr_clr   (ovr_clr),
        .integ_en  (integ_en),
        .comb_en   (comb_en),
        .cic_valid (cic_valid),
        .cic_data  (cic_data),
        .out_byte  (out_byte),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_first (out_first),
        .out_last  (out_last),
        .overrun   (overrun),
        .rate      (rate)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: samples in current group, rate in force, pending rate,
    // and a queue of bytes still owed downstream ({first, last, byte}).
    int         m_cnt, m_rate, m_pending;
    bit         m_integ, m_comb, m_ovr;
    logic [9:0] mq[$];

    // Observations used by the directed checks
    int         strobe_no;
    int         integ_seen;
    int         comb_at[$];
    logic [7:0] seen_bytes[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic model_update(input bit rs, input bit iv, input bit we, input logic [7:0] r,
                                input bit clr, input bit cv, input logic [15:0] d,
                                input bit rdy);
        bit drop;
        if (rs) begin
            m_cnt = 0; m_rate = 32; m_pending = 32;
            m_integ = 0; m_comb = 0; m_ovr = 0;
            mq.delete();
            return;
        end
        m_integ = iv;
        m_comb  = 0;
        if (iv) begin
            m_cnt++;
            if (m_cnt == m_rate) begin
                m_cnt  = 0;
                m_comb = 1;
                m_rate = m_pending;
            end
        end
        if (we) m_pending = (int'(r) < 2) ? 2 : int'(r);

        if (mq.size() > 0 && rdy) void'(mq.pop_front());
        drop = 0;
        if (cv) begin
            if (mq.size() == 0) begin
                mq.push_back({1'b1, 1'b0, d[15:8]});
                mq.push_back({1'b0, 1'b1, d[7:0]});
            end else begin
                drop = 1;
            end
        end
        if (drop) m_ovr = 1;
        else if (clr) m_ovr = 0;
    endtask

    task automatic compare_model();
        logic [9:0] head;
        head = (mq.size() > 0) ? mq[0] : 10'd0;
        chk("integ_en", integ_en, m_integ);
        chk("comb_en", comb_en, m_comb);
        chk("rate", rate, m_rate);
        chk("out_valid", out_valid, mq.size() > 0);
        chk("out_first", out_first, head[9]);
        chk("out_last", out_last, head[8]);
        chk("overrun", overrun, m_ovr);
        if (mq.size() > 0) chk("out_byte", out_byte, head[7:0]);
    endtask

    task automatic step(input bit rs, input bit iv, input bit we, input logic [7:0] r,
                        input bit clr, input bit cv, input logic [15:0] d, input bit rdy);
        rst = rs; in_valid = iv; cfg_we = we; cfg_rate = r; ovr_clr = clr;
        cic_valid = cv; cic_data = d; out_ready = rdy;
        if (!rs && out_valid === 1'b1 && rdy) seen_bytes.push_back(out_byte);
        if (!rs && iv) strobe_no++;
        model_update(rs, iv, we, r, clr, cv, d, rdy);
        @(negedge clk);
        compare_model();
        if (comb_en === 1'b1) comb_at.push_back(strobe_no);
        if (integ_en === 1'b1) integ_seen++;
    endtask

    task automatic do_reset();
        step(1, 0, 0, 8'd0, 0, 0, 16'd0, 0);
    endtask

    task automatic strobes(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 8'd0, 0, 0, 16'd0, 0);
    endtask

    task automatic clear_obs();
        strobe_no = 0; integ_seen = 0;
        comb_at.delete(); seen_bytes.delete();
    endtask

    initial begin
        rst = 1; in_valid = 0; cfg_we = 0; cfg_rate = 0; ovr_clr = 0;
        cic_valid = 0; cic_data = 0; out_ready = 0;
        clear_obs();

        // Reset in the middle of a stalled word with overrun set
        do_reset();
        do_reset();
        step(0, 0, 0, 8'd0, 0, 1, 16'hA55A, 0);
        step(0, 0, 0, 8'd0, 0, 1, 16'h1111, 0);
        chk("pre_rst_overrun", overrun, 1);
        do_reset();
        chk("rst_rate", rate, 32);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_byte", out_byte, 0);
        chk("rst_first_last", {out_first, out_last}, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_enables", {integ_en, comb_en}, 0);
        clear_obs();
        strobes(32);
        chk("rst_first_comb_n", comb_at.size(), 1);
        chk("rst_first_comb_at", comb_at[0], 32);

        // Default decimation over 96 back-to-back strobes
        clear_obs();
        strobes(96);
        chk("dec_integ_cnt", integ_seen, 96);
        chk("dec_comb_cnt", comb_at.size(), 3);
        chk("dec_comb0", comb_at[0], 32);
        chk("dec_comb1", comb_at[1], 64);
        chk("dec_comb2", comb_at[2], 96);

        // Rate change applied on the boundary only
        do_reset();
        clear_obs();
        strobes(10);
        step(0, 0, 1, 8'd4, 0, 0, 16'd0, 0);
        strobes(21);
        chk("rc_rate_held", rate, 32);
        strobes(9);
        chk("rc_comb_cnt", comb_at.size(), 3);
        chk("rc_comb0", comb_at[0], 32);
        chk("rc_comb1", comb_at[1], 36);
        chk("rc_comb2", comb_at[2], 40);
        chk("rc_rate4", rate, 4);
        step(0, 0, 1, 8'd1, 0, 0, 16'd0, 0);
        strobes(4);
        chk("rc_clamp_rate", rate, 2);
        chk("rc_comb3", comb_at[3], 44);

        // Serialize with backpressure
        do_reset();
        step(0, 0, 0, 8'd0, 0, 1, 16'hA55A, 0);
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold_byte", out_byte, 8'hA5);
            chk("bp_hold_first", {out_valid, out_first, out_last}, 3'b110);
            step(0, 0, 0, 8'd0, 0, 0, 16'd0, 0);
        end
        step(0, 0, 0, 8'd0, 0, 0, 16'd0, 1);
        chk("bp_second_byte", out_byte, 8'h5A);
        chk("bp_second_last", {out_valid, out_first, out_last}, 3'b101);
        step(0, 0, 0, 8'd0, 0, 0, 16'd0, 1);
        chk("bp_idle", out_valid, 0);

        // Back-to-back words via last-byte handshake
        clear_obs();
        step(0, 0, 0, 8'd0, 0, 1, 16'hBEEF, 1);
        step(0, 0, 0, 8'd0, 0, 0, 16'd0, 1);
        step(0, 0, 0, 8'd0, 0, 1, 16'h1234, 1);
        step(0, 0, 0, 8'd0, 0, 0, 16'd0, 1);
        step(0, 0, 0, 8'd0, 0, 0, 16'd0, 1);
        chk("b2b_nbytes", seen_bytes.size(), 4);
        chk("b2b_byte0", seen_bytes[0], 8'hBE);
        chk("b2b_byte1", seen_bytes[1], 8'hEF);
        chk("b2b_byte2", seen_bytes[2], 8'h12);
        chk("b2b_byte3", seen_bytes[3], 8'h34);
        chk("b2b_overrun", overrun, 0);

        // Overrun set, clear, and set-wins-over-clear
        step(0, 0, 0, 8'd0, 0, 1, 16'h1111, 0);
        step(0, 0, 0, 8'd0, 0, 1, 16'h2222, 0);
        chk("ovr_set", overrun, 1);
        chk("ovr_word_kept", out_byte, 8'h11);
        step(0, 0, 0, 8'd0, 1, 0, 16'd0, 0);
        chk("ovr_clr", overrun, 0);
        step(0, 0, 0, 8'd0, 1, 1, 16'h3333, 0);
        chk("ovr_set_wins", overrun, 1);
        step(0, 0, 0, 8'd0, 0, 0, 16'd0, 1);
        step(0, 0, 0, 8'd0, 0, 0, 16'd0, 1);
        chk("ovr_drained", out_valid, 0);

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            logic [7:0] r;
            r = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(2, 12));
            step(($urandom_range(0, 499) == 0),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 29) == 0),
                 r,
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 9) == 0),
                 16'($urandom),
                 ($urandom_range(0, 9) < 6));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cic_dec_ctrl.md
# cic_dec_ctrl

Sequencing controller for the CIC decimation datapath in the `tt_um_lime_cic_filter` tile. It counts input samples, issues the integrator and comb enables at the programmed decimation rate, and applies rate changes only on decimation boundaries. It also serializes each multi-byte CIC output word onto an 8-bit valid/ready byte stream with first/last framing and reports overruns. It sits between the pad-level input strobe, the CIC integrator/comb stages, and the 8-bit output pins.

## Interface
- `RATE_W`, 8: width of the decimation-rate register.
- `DEFAULT_RATE`, 32: decimation rate after reset; must be ≥ 2.
- `NBYTES`, 2: bytes per CIC output word; word width is 8·NBYTES.

Ports:
- `clk`  in  1  single clock for the whole block.
- `rst`  in  1  synchronous reset, active-high.
- `in_valid`  in  1  one-cycle strobe, one input sample present.
- `cfg_we`  in  1  write strobe for the decimation rate.
- `cfg_rate`  in  RATE_W  new decimation rate.
- `ovr_clr`  in  1  clears the sticky overrun flag.
- `integ_en`  out  1  integrator advance enable.
- `comb_en`  out  1  comb advance enable, once per R accepted samples.
- `cic_valid`  in  1  comb output word valid, one-cycle pulse.
- `cic_data`  in  8·NBYTES  comb output word.
- `out_byte`  out  8  serialized byte, most-significant byte first.
- `out_valid`  out  1  `out_byte` is valid.
- `out_ready`  in  1  downstream accepts the byte.
- `out_first` / `out_last`  out  1 each  byte is the first / last byte of the word.
- `overrun`  out  1  sticky flag: a word was dropped.
- `rate`  out  RATE_W  decimation rate currently in force.

## Operation
- **Reset:**
  - `cnt` = 0, `rate` = `pending` = DEFAULT_RATE.
  - `integ_en`, `comb_en`, `out_valid`, `out_first`, `out_last` and `overrun` are 0.
  - `out_byte` = 0; FSM is in IDLE.
  - Reset mid-word aborts the word with no partial bytes.
- **Rate write:** `cfg_we` latches `cfg_rate` into `pending`. Values 0 or 1 are clamped to 2. A later write in the same group overwrites `pending`.
- **Sample counting:** on each `in_valid`:
  - If `cnt == rate-1`: `cnt` becomes 0, a comb pulse is issued, and `rate` takes the value of `pending`.
  - Otherwise `cnt` increments.
  - `rate` never changes mid-group.
  - A `cfg_we` in the same cycle as the boundary `in_valid` lands in `pending` and applies at the next boundary.
- **Serializer FSM:**
  - IDLE: on `cic_valid`, latch `cic_data`, set `idx` = NBYTES-1, go to SEND.
  - SEND: `out_byte` = byte[`idx`] of the latched word, `out_valid` = 1, `out_first` = (`idx` == NBYTES-1), `out_last` = (`idx` == 0).
  - SEND, on `out_valid && out_ready`:
    - If `idx` > 0: decrement `idx`.
    - Else: go to IDLE.
  - Last-byte handshake and `cic_valid` in the same cycle: latch the new word and stay in SEND with `idx` = NBYTES-1. This is not an overrun.
  - `cic_valid` in SEND at any other time: drop the word and set `overrun`.
  - `out_byte` holds its value while `out_valid && !out_ready`.
- **Overrun flag:**
  - `ovr_clr` clears `overrun`.
  - If a set and a clear occur in the same cycle, the set wins.

## Timing
- `integ_en` and `comb_en` are registered; each is high for exactly one cycle, the cycle after the qualifying `in_valid`. They are aligned with each other.
- `rate` output updates in the same cycle as that boundary's `comb_en`.
- `cic_valid` → first byte `out_valid`: 1 cycle, registered.
- Throughput with `out_ready` held high: one byte per cycle. Back-to-back words with no bubble are possible via the same-cycle last-byte rule.
- `out_valid`, once raised, stays high until the handshake completes.
- `in_valid` on consecutive cycles is legal; every strobe is counted.

## Test plan
- **Reset defaults:** assert `rst` mid-SEND with `out_valid` = 1 → next cycle all outputs are 0, `rate` = 32, and the first `comb_en` occurs on the 32nd subsequent `in_valid`.
- **Default decimation:** 96 `in_valid` strobes on every cycle →
  - 96 `integ_en` pulses;
  - `comb_en` exactly 3 times, one cycle after strobes 32, 64 and 96.
- **Rate change on boundary:** write `cfg_rate` = 4 after strobe 10 → `rate` stays 32 until strobe 32, then `comb_en` occurs after strobes 36, 40, … Write `cfg_rate` = 1 → `rate` becomes 2.
- **Serialize with backpressure:** `cic_data` = 0xA55A, `out_ready` low for 3 cycles →
  - `out_byte` = 0xA5 held with `out_first` = 1;
  - then 0x5A with `out_last` = 1;
  - then IDLE.
- **Back-to-back words:** `cic_valid` with 0x1234 on the last-byte handshake of 0xBEEF → bytes BE, EF, 12, 34 on consecutive cycles; `overrun` = 0.
- **Overrun:** `cic_valid` while the first byte is stalled → word dropped and `overrun` = 1. `ovr_clr` alone clears it. `ovr_clr` together with a new drop in the same cycle leaves `overrun` = 1.
